// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download router: FSM states and the region range record.
package rom_dl_pkg;

    localparam int unsigned ADDR_W = 25;
    localparam int unsigned WORD_W = 23;
    localparam int unsigned WCNT_W = 16;
    localparam int unsigned RCNT_W = 17;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } dl_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] first;
        logic [ADDR_W-1:0] last;
    } region_t;

endpackage

// File: rtl/dl_region_match.sv
// Decides whether a byte address falls in one port's inclusive region and
// gives the 16-bit word offset from the region start.
module dl_region_match
    import rom_dl_pkg::*;
(
    input  logic [ADDR_W-1:0] addr_i,
    input  region_t           region_i,
    output logic              hit_o,
    output logic [WORD_W-1:0] word_o
);

    logic [ADDR_W-1:0] diff;

    assign diff   = addr_i - region_i.first;
    assign hit_o  = (addr_i >= region_i.first) && (addr_i <= region_i.last);
    assign word_o = WORD_W'(diff >> 1);

endmodule

// File: rtl/rom_dl_router.sv
// Routes HPS ROM-download bytes to one or more SDRAM toggle-handshake write
// ports, throttles the HPS, and stretches the game-core reset after loading.
module rom_dl_router
    import rom_dl_pkg::*;
#(
    parameter int unsigned            NPORTS      = 2,
    parameter logic [7:0]             ROM_INDEX   = 8'd0,
    parameter logic [NPORTS*ADDR_W-1:0] REGION_BASE = {25'h30000, 25'h0},
    parameter logic [NPORTS*ADDR_W-1:0] REGION_END  = {25'h8FFFF, 25'h2FFFF},
    parameter int unsigned            RST_CYCLES  = 65535,
    parameter int unsigned            ACK_TIMEOUT = 255
) (
    input  logic                       clk_sys,
    input  logic                       reset,
    input  logic                       user_reset,
    input  logic                       ioctl_download,
    input  logic [7:0]                 ioctl_index,
    input  logic                       ioctl_wr,
    input  logic [ADDR_W-1:0]          ioctl_addr,
    input  logic [7:0]                 ioctl_dout,
    input  logic [NPORTS-1:0]          port_ack,
    output logic [NPORTS-1:0]          port_req,
    output logic [NPORTS*WORD_W-1:0]   port_a,
    output logic [1:0]                 port_ds,
    output logic [15:0]                port_d,
    output logic                       port_we,
    output logic                       dl_active,
    output logic                       ioctl_wait,
    output logic                       ack_err,
    output logic                       rom_loaded,
    output logic                       core_reset
);

    dl_state_e                 state_q;
    logic                      wr_prev_q;
    logic                      dl_prev_q;
    logic [ADDR_W-1:0]         addr_q;
    logic                      pend_q;
    logic [ADDR_W-1:0]         pend_addr_q;
    logic [7:0]                pend_data_q;
    logic [NPORTS-1:0]         req_q;
    logic [NPORTS-1:0]         toggled_q;
    logic [NPORTS*WORD_W-1:0]  port_a_q;
    logic [1:0]                ds_q;
    logic [15:0]               d_q;
    logic [WCNT_W-1:0]         wcnt_q;
    logic                      ack_err_q;
    logic                      rom_loaded_q;
    logic [RCNT_W-1:0]         rcnt_q;
    logic                      core_reset_q;

    logic [NPORTS-1:0]         hit_c;
    logic [NPORTS*WORD_W-1:0]  word_c;
    logic                      wr_rise_c;

    assign dl_active  = ioctl_download && (ioctl_index == ROM_INDEX);
    assign port_we    = dl_active;
    assign wr_rise_c  = ioctl_wr && !wr_prev_q && dl_active;
    assign ioctl_wait = (state_q != ST_IDLE);
    assign port_req   = req_q;
    assign port_a     = port_a_q;
    assign port_ds    = ds_q;
    assign port_d     = d_q;
    assign ack_err    = ack_err_q;
    assign rom_loaded = rom_loaded_q;
    assign core_reset = core_reset_q;

    for (genvar i = 0; i < NPORTS; i++) begin : g_port
        region_t rgn;
        assign rgn.first = REGION_BASE[i*ADDR_W +: ADDR_W];
        assign rgn.last  = REGION_END[i*ADDR_W +: ADDR_W];

        dl_region_match u_match (
            .addr_i   (addr_q),
            .region_i (rgn),
            .hit_o    (hit_c[i]),
            .word_o   (word_c[i*WORD_W +: WORD_W])
        );
    end

    // Write FSM plus the one-deep pending slot for strobes arriving while busy.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_prev_q   <= 1'b0;
            addr_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            req_q       <= '0;
            toggled_q   <= '0;
            port_a_q    <= '0;
            ds_q        <= '0;
            d_q         <= '0;
            wcnt_q      <= '0;
            ack_err_q   <= 1'b0;
        end else begin
            wr_prev_q <= ioctl_wr;
            unique case (state_q)
                ST_IDLE: begin
                    if (pend_q) begin
                        addr_q  <= pend_addr_q;
                        ds_q    <= {pend_addr_q[0], ~pend_addr_q[0]};
                        d_q     <= {pend_data_q, pend_data_q};
                        state_q <= ST_ISSUE;
                    end else if (wr_rise_c) begin
                        addr_q  <= ioctl_addr;
                        ds_q    <= {ioctl_addr[0], ~ioctl_addr[0]};
                        d_q     <= {ioctl_dout, ioctl_dout};
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    req_q     <= req_q ^ hit_c;
                    toggled_q <= hit_c;
                    wcnt_q    <= '0;
                    for (int i = 0; i < int'(NPORTS); i++) begin
                        if (hit_c[i]) begin
                            port_a_q[i*WORD_W +: WORD_W] <= word_c[i*WORD_W +: WORD_W];
                        end
                    end
                    state_q <= (|hit_c) ? ST_WAIT_ACK : ST_IDLE;
                end
                ST_WAIT_ACK: begin
                    if (((port_ack ^ req_q) & toggled_q) == '0) begin
                        state_q <= ST_IDLE;
                    end else if (wcnt_q == WCNT_W'(ACK_TIMEOUT)) begin
                        state_q   <= ST_IDLE;
                        ack_err_q <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // An IDLE strobe with the slot empty is taken directly above.
            if (wr_rise_c && (state_q != ST_IDLE || pend_q)) begin
                if (pend_q && state_q != ST_IDLE) begin
                    ack_err_q <= 1'b1;
                end else begin
                    pend_q      <= 1'b1;
                    pend_addr_q <= ioctl_addr;
                    pend_data_q <= ioctl_dout;
                end
            end else if (state_q == ST_IDLE && pend_q) begin
                pend_q <= 1'b0;
            end
        end
    end

    // Download-complete flag and the core reset stretcher.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_prev_q    <= 1'b0;
            rom_loaded_q <= 1'b0;
            rcnt_q       <= RCNT_W'(RST_CYCLES);
            core_reset_q <= 1'b1;
        end else begin
            dl_prev_q <= dl_active;
            if (dl_prev_q && !dl_active) begin
                rom_loaded_q <= 1'b1;
            end
            if (user_reset || !rom_loaded_q || dl_active) begin
                rcnt_q <= RCNT_W'(RST_CYCLES);
            end else if (rcnt_q != '0) begin
                rcnt_q <= rcnt_q - 1'b1;
            end
            core_reset_q <= (rcnt_q != '0);
        end
    end

endmodule
